dp_exec_unit: RTL and testbench

//  Datapath executor downstream of the evolution controller. Accepts one instruction per start pulse
//  {operand, addr, opcode}, performs it on an internal dual-port data RAM (food coords, scores, scratch),

---
 rtl/dp_exec_unit_pkg.sv | 34 +++
 rtl/dp_ram_2p.sv | 38 +++
 rtl/dp_exec_unit.sv | 156 +++++++++++++++
 tb/tb_dp_exec_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_exec_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dp_exec_unit_pkg                                                   |
// | Instruction layout, opcodes and RAM address map shared with ctrl.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package dp_exec_unit_pkg;

    localparam int DP_DATA_W  = 16;
    localparam int DP_ADDR_W  = 8;
    localparam int DP_OP_W    = 4;
    localparam int DP_INSTR_W = DP_DATA_W + DP_ADDR_W + DP_OP_W;

    localparam logic [DP_OP_W-1:0] OP_NOP      = 4'd0;
    localparam logic [DP_OP_W-1:0] OP_MEMREAD  = 4'd1;
    localparam logic [DP_OP_W-1:0] OP_MEMWRITE = 4'd2;
    localparam logic [DP_OP_W-1:0] OP_MEMADD   = 4'd3;

    // Word address map of the data RAM
    localparam logic [DP_ADDR_W-1:0] FOOD_X_BASE  = 8'h00;
    localparam logic [DP_ADDR_W-1:0] FOOD_Y_BASE  = 8'h10;
    localparam logic [DP_ADDR_W-1:0] SCORE_BASE   = 8'h20;
    localparam logic [DP_ADDR_W-1:0] SCRATCH_BASE = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_DONE_RD  = 3'd3,
        ST_ADD_WB   = 3'd4
    } exec_state_e;

endpackage
`default_nettype wire

// File: rtl/dp_ram_2p.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dp_ram_2p                                                          |
// | DEPTH x DATA_W RAM: port A sync read/write, port B sync read.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dp_ram_2p #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Reads sample the array before this edge's write lands: read-old-data
    always_ff @(posedge clock) begin
        if (a_we) begin
            mem_q[a_addr] <= a_wdata;
        end
        a_rdata_q <= mem_q[a_addr];
        b_rdata_q <= mem_q[b_addr];
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/dp_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dp_exec_unit                                                       |
// | Executes one {operand,addr,opcode} instruction per start edge.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dp_exec_unit
    import dp_exec_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 256
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [DATA_W+ADDR_W+OP_W-1:0]   instruction,
    output logic                            finished,
    output logic [DATA_W-1:0]               result,
    output logic                            error,
    input  logic [ADDR_W-1:0]               rd_addr,
    output logic [DATA_W-1:0]               rd_data
);

    localparam int                INSTR_W   = DATA_W + ADDR_W + OP_W;
    localparam logic [ADDR_W:0]   DEPTH_LIM = DEPTH[ADDR_W:0];
    localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    exec_state_e        state_q, state_d;
    logic               start_q;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               finished_q, finished_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               error_q, error_d;

    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    function automatic logic is_bad(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= DEPTH_LIM) || (op > OP_MEMADD);
    endfunction

    logic [OP_W-1:0]   in_op, q_op;
    logic [ADDR_W-1:0] in_addr, q_addr;
    logic [DATA_W-1:0] q_operand;
    logic              in_bad, q_bad, launch;

    assign in_op     = instruction[OP_W-1:0];
    assign in_addr   = instruction[OP_W +: ADDR_W];
    assign q_op      = instr_q[OP_W-1:0];
    assign q_addr    = instr_q[OP_W +: ADDR_W];
    assign q_operand = instr_q[INSTR_W-1 -: DATA_W];
    assign in_bad    = is_bad(in_op, in_addr);
    assign q_bad     = is_bad(q_op, q_addr);
    assign launch    = (state_q == ST_IDLE) && start && !start_q;

    // Sign-extended sum; overflow shows as disagreement of the top two bits
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] sat_w;
    assign sum_w = {ram_rdata[DATA_W-1], ram_rdata} + {q_operand[DATA_W-1], q_operand};
    assign sat_w = (sum_w[DATA_W] != sum_w[DATA_W-1]) ? (sum_w[DATA_W] ? SAT_MIN : SAT_MAX)
                                                       : sum_w[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        finished_d = finished_q;
        result_d   = result_q;
        error_d    = error_q;
        ram_we     = 1'b0;
        ram_wdata  = q_operand;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    instr_d    = instruction;
                    finished_d = 1'b0;
                    if (!in_bad && (in_op == OP_MEMREAD || in_op == OP_MEMADD)) begin
                        state_d = ST_RD_ISSUE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            // Single-cycle completion: NOP, MEMWRITE and every rejected instruction
            ST_WRITE: begin
                ram_we     = (q_op == OP_MEMWRITE) && !q_bad;
                result_d   = ram_we ? q_operand : '0;
                error_d    = q_bad;
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                state_d = (q_op == OP_MEMADD) ? ST_ADD_WB : ST_DONE_RD;
            end
            ST_DONE_RD: begin
                result_d   = ram_rdata;
                error_d    = 1'b0;
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_ADD_WB: begin
                ram_we     = 1'b1;
                ram_wdata  = sat_w;
                result_d   = sat_w;
                error_d    = 1'b0;
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            instr_q    <= '0;
            finished_q <= 1'b1;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            instr_q    <= instr_d;
            finished_q <= finished_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

    // A write due on the same edge as a reset is dropped
    dp_ram_2p #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .a_we    (ram_we && resetn),
        .a_addr  (q_addr),
        .a_wdata (ram_wdata),
        .a_rdata (ram_rdata),
        .b_addr  (rd_addr),
        .b_rdata (rd_data)
    );

    assign finished = finished_q;
    assign result   = result_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dp_exec_unit                                                    |
// | Directed bench with a transaction-level model and per-cycle check. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dp_exec_unit;

    localparam int TB_DEPTH = 200;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [27:0] instruction = '0;
    logic        finished;
    logic [15:0] result;
    logic        error;
    logic [7:0]  rd_addr = 8'd3;
    logic [15:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    dp_exec_unit #(
        .DATA_W (16),
        .ADDR_W (8),
        .OP_W   (4),
        .DEPTH  (TB_DEPTH)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .instruction (instruction),
        .finished    (finished),
        .result      (result),
        .error       (error),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = $signed(a) + $signed(b);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    // Transaction-level model: memory image, pending instruction, cycles to completion
    logic [15:0] mm [256];
    bit          mk [256];
    bit          m_fin = 1'b1;
    logic [15:0] m_res = '0;
    bit          m_err = 1'b0;
    int          m_busy = 0;
    bit          m_sq = 1'b0;
    logic [3:0]  p_op;
    logic [7:0]  p_addr;
    logic [15:0] p_opnd;
    bit          p_bad;
    logic [15:0] m_rd;
    bit          m_rd_ok = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) mk[i] = 1'b0;
    end

    always @(posedge clock) begin
        m_rd    <= mm[rd_addr];
        m_rd_ok <= mk[rd_addr] && (int'(rd_addr) < TB_DEPTH);
        if (!resetn) begin
            m_fin  <= 1'b1;
            m_res  <= '0;
            m_err  <= 1'b0;
            m_busy <= 0;
            m_sq   <= 1'b0;
        end else begin
            m_sq <= start;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_fin <= 1'b1;
                    m_err <= p_bad;
                    if (p_bad) begin
                        m_res <= '0;
                    end else begin
                        case (p_op)
                            4'd1: m_res <= mm[p_addr];
                            4'd2: begin
                                m_res <= p_opnd;
                                mm[p_addr] <= p_opnd;
                                mk[p_addr] <= 1'b1;
                            end
                            4'd3: begin
                                m_res <= sat16(mm[p_addr], p_opnd);
                                mm[p_addr] <= sat16(mm[p_addr], p_opnd);
                            end
                            default: m_res <= '0;
                        endcase
                    end
                end
            end else if (start && !m_sq) begin
                p_op   <= instruction[3:0];
                p_addr <= instruction[11:4];
                p_opnd <= instruction[27:12];
                p_bad  <= (int'(instruction[11:4]) >= TB_DEPTH) || (instruction[3:0] > 4'd3);
                m_fin  <= 1'b0;
                if ((int'(instruction[11:4]) < TB_DEPTH) &&
                    (instruction[3:0] == 4'd1 || instruction[3:0] == 4'd3))
                    m_busy <= 2;
                else
                    m_busy <= 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_finished", {31'd0, finished}, {31'd0, m_fin});
            chk("cyc_result", {16'd0, result}, {16'd0, m_res});
            chk("cyc_error", {31'd0, error}, {31'd0, m_err});
            if (m_rd_ok) chk("cyc_rd_data", {16'd0, rd_data}, {16'd0, m_rd});
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [7:0] addr, input logic [15:0] opnd,
                          output logic [15:0] res, output logic err, output int lat);
        @(negedge clock);
        instruction = {opnd, addr, op};
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!finished && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (lat >= 20) chk("op_timeout", 32'd0, 32'd1);
        res = result;
        err = error;
    endtask

    logic [15:0] r;
    logic        e;
    int          l;

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_finished", {31'd0, finished}, 32'd1);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // write then read back
        run_op(4'd2, 8'd5, 16'h0123, r, e, l);
        chk("wr_result", {16'd0, r}, 32'h0123);
        chk("wr_latency", l, 32'd1);
        run_op(4'd1, 8'd5, 16'h0000, r, e, l);
        chk("rd_result", {16'd0, r}, 32'h0123);
        chk("rd_latency", l, 32'd2);
        run_op(4'd0, 8'd5, 16'h7777, r, e, l);
        chk("nop_result", {16'd0, r}, 32'd0);
        chk("nop_latency", l, 32'd1);

        // saturating add
        run_op(4'd2, 8'd7, 16'h7FF0, r, e, l);
        run_op(4'd3, 8'd7, 16'h0020, r, e, l);
        chk("add_pos_sat", {16'd0, r}, 32'h7FFF);
        chk("add_latency", l, 32'd2);
        run_op(4'd2, 8'd7, 16'h8005, r, e, l);
        run_op(4'd3, 8'd7, 16'hFFF0, r, e, l);
        chk("add_neg_sat", {16'd0, r}, 32'h8000);
        run_op(4'd2, 8'd7, 16'h0010, r, e, l);
        run_op(4'd3, 8'd7, 16'hFFFF, r, e, l);
        chk("add_no_sat", {16'd0, r}, 32'h000F);
        run_op(4'd1, 8'd7, 16'h0000, r, e, l);
        chk("add_stored", {16'd0, r}, 32'h000F);

        // start held high: one launch only
        run_op(4'd2, 8'd9, 16'h0000, r, e, l);
        @(negedge clock);
        instruction = {16'h0001, 8'd9, 4'd3};
        start = 1'b1;
        repeat (6) @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        run_op(4'd1, 8'd9, 16'h0000, r, e, l);
        chk("held_start_once", {16'd0, r}, 32'd1);
        run_op(4'd3, 8'd9, 16'h0001, r, e, l);
        chk("second_launch", {16'd0, r}, 32'd2);

        // bad address and illegal opcode
        run_op(4'd2, 8'hFF, 16'hBEEF, r, e, l);
        chk("badaddr_result", {16'd0, r}, 32'd0);
        chk("badaddr_error", {31'd0, e}, 32'd1);
        chk("badaddr_latency", l, 32'd1);
        run_op(4'hA, 8'd5, 16'h9999, r, e, l);
        chk("illop_result", {16'd0, r}, 32'd0);
        chk("illop_error", {31'd0, e}, 32'd1);
        run_op(4'd1, 8'd5, 16'h0000, r, e, l);
        chk("after_err_data", {16'd0, r}, 32'h0123);
        chk("after_err_error", {31'd0, e}, 32'd0);

        // reset during MEMADD
        run_op(4'd2, 8'd11, 16'h0100, r, e, l);
        @(negedge clock);
        instruction = {16'h0005, 8'd11, 4'd3};
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        chk("midrst_finished", {31'd0, finished}, 32'd1);
        chk("midrst_result", {16'd0, result}, 32'd0);
        resetn = 1'b1;
        run_op(4'd1, 8'd11, 16'h0000, r, e, l);
        chk("midrst_word", {16'd0, r}, 32'h0100);

        // port B read-old-data on colliding write
        run_op(4'd2, 8'd3, 16'h1111, r, e, l);
        rd_addr = 8'd3;
        @(negedge clock);
        instruction = {16'h5555, 8'd3, 4'd2};
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("portb_old", {16'd0, rd_data}, 32'h1111);
        @(negedge clock);
        chk("portb_new", {16'd0, rd_data}, 32'h5555);

        rd_addr = 8'd7;
        repeat (3) @(negedge clock);
        chk("portb_addr7", {16'd0, rd_data}, 32'h000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
